// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Instruction-fetch front end. Owns the program counter, drives
//             the combinational instruction ROM, captures the returned word
//             into a registered fetch slot and hands it to decode over a
//             valid/ready handshake. Accepts branch redirects from execute
//             and stops on the all-zero end-of-program word.
//  Ports    : clk, rst          - clock / asynchronous active-high reset
//             imem_addr   (out) - byte address to ROM (= pc)
//             imem_instr  (in)  - ROM word for imem_addr, same cycle
//             branch_valid/branch_target (in) - redirect request
//             out_valid/out_ready/out_instr/out_pc - fetch slot to decode
//             halted      (out) - fetch stopped on zero word
//             fetch_count (out) - saturating count of completed handshakes
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 32,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 4,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_pc_step  = ADDR_W'(PC_STEP);
    // Redirect targets are word aligned: the two low address bits are dropped.
    localparam logic [ADDR_W-1:0] c_align    = ~ADDR_W'(3);

    typedef enum logic [0:0] {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t             r_state,       w_state_nxt;
    logic [ADDR_W-1:0]  r_pc,          w_pc_nxt;
    logic               r_out_valid,   w_out_valid_nxt;
    logic [INSTR_W-1:0] r_out_instr,   w_out_instr_nxt;
    logic [ADDR_W-1:0]  r_out_pc,      w_out_pc_nxt;
    logic               r_halted,      w_halted_nxt;
    logic [CNT_W-1:0]   r_fetch_count, w_fetch_count_nxt;
    logic               w_load_en;
    logic               w_handshake;

    // Slot can take a new word when empty or being drained this cycle.
    assign w_load_en   = !r_out_valid || out_ready;
    assign w_handshake = r_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_FETCH;
            r_pc          <= c_reset_pc;
            r_out_valid   <= 1'b0;
            r_out_instr   <= '0;
            r_out_pc      <= '0;
            r_halted      <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_instr   <= w_out_instr_nxt;
            r_out_pc      <= w_out_pc_nxt;
            r_halted      <= w_halted_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_out_valid_nxt   = r_out_valid;
        w_out_instr_nxt   = r_out_instr;
        w_out_pc_nxt      = r_out_pc;
        w_halted_nxt      = r_halted;
        w_fetch_count_nxt = r_fetch_count;

        // Handshake counting is independent of redirects: a slot accepted in
        // the same cycle as a flush was still delivered.
        if (w_handshake && !(&r_fetch_count)) begin
            w_fetch_count_nxt = r_fetch_count + 1'b1;
        end

        if (branch_valid) begin
            w_pc_nxt        = branch_target & c_align;
            w_out_valid_nxt = 1'b0;
            w_halted_nxt    = 1'b0;
            w_state_nxt     = ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_load_en) begin
                        if (imem_instr != '0) begin
                            w_out_instr_nxt = imem_instr;
                            w_out_pc_nxt    = r_pc;
                            w_out_valid_nxt = 1'b1;
                            w_pc_nxt        = r_pc + c_pc_step;
                        end else begin
                            // End-of-program word: never shown to decode.
                            w_out_valid_nxt = 1'b0;
                            w_halted_nxt    = 1'b1;
                            w_state_nxt     = ST_HALTED;
                        end
                    end
                end
                ST_HALTED: begin
                    w_out_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_FETCH;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_pc      = r_out_pc;
    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Self-checking bench for instr_fetch_unit. A behavioural ROM
//             answers imem_addr; expected (instr, pc) pairs are queued as
//             each scenario is set up and popped on every handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 16;

    logic               clk;
    logic               rst;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               branch_valid;
    logic [ADDR_W-1:0]  branch_target;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               halted;
    logic [CNT_W-1:0]   fetch_count;

    typedef struct {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic allnz  = 1'b0;

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (0),
        .PC_STEP  (4),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [INSTR_W-1:0] rom(input logic [ADDR_W-1:0] a, input logic nz);
        logic [INSTR_W-1:0] d;
        if (nz) begin
            d = 32'hC000_0000 | {24'd0, a};
        end else begin
            case (a)
                8'd0:    d = 32'h4000_0000;
                8'd4:    d = 32'h4100_0010;
                8'd8:    d = 32'h4200_0001;
                8'd12:   d = 32'h4300_0000;
                8'd16:   d = 32'h3030_0000;
                8'd20:   d = 32'h0332_0000;
                8'd24:   d = 32'h5031_0010;
                default: d = 32'h0;
            endcase
        end
        return d;
    endfunction

    assign imem_instr = rom(imem_addr, allnz);

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [INSTR_W-1:0] i, input logic [ADDR_W-1:0] p);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        sbq.push_back(e);
    endtask

    // Observes the handshake about to happen, then advances one clock and
    // settles 2 time units past the edge.
    task automatic tick();
        exp_t e;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check_val("sb_unexpected", out_instr, 0);
            end else begin
                e = sbq.pop_front();
                check_val("sb_instr", out_instr, e.instr);
                check_val("sb_pc", out_pc, e.pc);
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic redirect(input logic [ADDR_W-1:0] t);
        branch_valid  = 1'b1;
        branch_target = t;
        tick();
        branch_valid  = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        out_ready     = 1'b1;
        branch_valid  = 1'b0;
        branch_target = '0;
        #12;
        check_val("rst_valid", out_valid, 0);
        check_val("rst_halted", halted, 0);
        check_val("rst_count", fetch_count, 0);
        check_val("rst_pc", imem_addr, 0);
        check_val("rst_instr", out_instr, 0);
        check_val("rst_outpc", out_pc, 0);

        // Straight-line program run to the end-of-program word.
        rst = 1'b0;
        push_exp(32'h4000_0000, 0);
        push_exp(32'h4100_0010, 4);
        push_exp(32'h4200_0001, 8);
        push_exp(32'h4300_0000, 12);
        push_exp(32'h3030_0000, 16);
        push_exp(32'h0332_0000, 20);
        push_exp(32'h5031_0010, 24);
        @(posedge clk);
        #2;
        check_val("lat_valid", out_valid, 1);
        for (int i = 0; i < 7; i++) tick();
        check_val("end_halted", halted, 1);
        check_val("end_valid", out_valid, 0);
        check_val("end_pc", imem_addr, 28);
        check_val("end_count", fetch_count, 7);
        check_val("end_sb", sbq.size(), 0);
        tick();
        tick();
        check_val("hold_halted", halted, 1);
        check_val("hold_pc", imem_addr, 28);
        check_val("hold_count", fetch_count, 7);

        // Leave HALTED by redirect; replay with a decode stall.
        redirect(8'd0);
        check_val("rd0_halted", halted, 0);
        check_val("rd0_valid", out_valid, 0);
        check_val("rd0_pc", imem_addr, 0);
        push_exp(32'h4000_0000, 0);
        push_exp(32'h4100_0010, 4);
        push_exp(32'h4200_0001, 8);
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("stall_valid", out_valid, 1);
            check_val("stall_instr", out_instr, 32'h4100_0010);
            check_val("stall_outpc", out_pc, 4);
            check_val("stall_pc", imem_addr, 8);
        end
        check_val("stall_count", fetch_count, 8);
        out_ready = 1'b1;
        tick();
        check_val("rel_instr", out_instr, 32'h4200_0001);
        tick();
        check_val("rel_count", fetch_count, 10);
        check_val("rel_sb", sbq.size(), 0);

        // Redirect flushes a stalled slot; target low bits are dropped.
        out_ready = 1'b0;
        redirect(8'h11);
        check_val("fl_valid", out_valid, 0);
        check_val("fl_pc", imem_addr, 8'h10);
        check_val("fl_count", fetch_count, 10);
        out_ready = 1'b1;
        tick();
        check_val("fl_instr", out_instr, 32'h3030_0000);
        check_val("fl_outpc", out_pc, 8'h10);

        // Redirect in the same cycle as an accepted handshake.
        push_exp(32'h3030_0000, 16);
        push_exp(32'h5031_0010, 24);
        redirect(8'h18);
        check_val("rdh_valid", out_valid, 0);
        check_val("rdh_pc", imem_addr, 24);
        check_val("rdh_count", fetch_count, 11);
        tick();
        tick();
        check_val("rdh_halted", halted, 1);
        check_val("rdh_count2", fetch_count, 12);
        check_val("rdh_sb", sbq.size(), 0);

        // PC wrap at the top of the address space.
        allnz = 1'b1;
        redirect(8'hF8);
        check_val("wr_pc", imem_addr, 8'hF8);
        check_val("wr_halted", halted, 0);
        push_exp(rom(8'd248, 1'b1), 8'd248);
        push_exp(rom(8'd252, 1'b1), 8'd252);
        push_exp(rom(8'd0, 1'b1), 8'd0);
        push_exp(rom(8'd4, 1'b1), 8'd4);
        tick();
        for (int i = 0; i < 4; i++) tick();
        check_val("wr_sb", sbq.size(), 0);
        check_val("wr_outpc", out_pc, 8);
        check_val("wr_pcnext", imem_addr, 12);
        check_val("wr_valid", out_valid, 1);

        // Asynchronous reset mid-stream, observed before any clock edge.
        rst = 1'b1;
        #1;
        check_val("arst_valid", out_valid, 0);
        check_val("arst_pc", imem_addr, 0);
        check_val("arst_count", fetch_count, 0);
        check_val("arst_halted", halted, 0);
        #10;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
